// File: rtl/u_stream_if.sv
// u_stream_if: input-word and result handshake bundle for u_stream
interface u_stream_if #(parameter int W = 16);
  localparam int CW = $clog2(W);
  logic          i_vld;
  logic          o_rdy;
  logic [W-1:0]  i_x;
  logic          i_admit_compliment;
  logic          o_vld;
  logic          i_rdy;
  logic          o_is_unary;
  logic          o_polarity;
  logic [CW-1:0] o_count;
  modport master (
    output i_vld, i_x, i_admit_compliment, i_rdy,
    input  o_rdy, o_vld, o_is_unary, o_polarity, o_count
  );
  modport slave (
    input  i_vld, i_x, i_admit_compliment, i_rdy,
    output o_rdy, o_vld, o_is_unary, o_polarity, o_count
  );
endinterface

// File: rtl/u_stream.sv
// u_stream: two-stage pipelined unary/complement-unary classifier with saturating reject counter
module u_stream #(
  parameter int W                     = 16,
  parameter bit P_ADMIT_COMPLIMENT_EN = 1,
  parameter int CNT_W                 = 16
) (
  input  logic             i_clk,
  input  logic             i_arst,
  u_stream_if.slave        st,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_reject_cnt
);
  localparam int CW = $clog2(W);
  logic          s1_vld, s2_vld, s1_adv, s2_adv, in_hs, out_hs, admit_c, s1_pol;
  logic [W-1:0]  std_m, cmp_m, s1_std, s1_cmp;
  logic [CW-1:0] enc;
  assign admit_c  = P_ADMIT_COMPLIMENT_EN && st.i_admit_compliment;
  assign s2_adv   = !s2_vld || st.i_rdy;
  assign s1_adv   = !s1_vld || s2_adv;
  assign st.o_rdy = !i_arst && s1_adv;
  assign in_hs    = st.i_vld && st.o_rdy;
  assign out_hs   = s2_vld && st.i_rdy;
  assign st.o_vld = s2_vld;
  // pivot k matches k trailing ones (standard) or k trailing zeros (complement)
  always_comb begin
    std_m = '0;
    cmp_m = '0;
    for (int k = 0; k < W; k++) begin
      std_m[k] = st.i_x == ({W{1'b1}} >> (W - k));
      cmp_m[k] = admit_c && (st.i_x == ~({W{1'b1}} >> (W - k)));
    end
  end
  always_comb begin
    enc = '0;
    for (int k = 0; k < W; k++)
      enc = (s1_std[k] || s1_cmp[k]) ? (enc | CW'(k)) : enc;
  end
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      s1_vld <= 1'b0;
      s1_std <= '0;
      s1_cmp <= '0;
      s1_pol <= 1'b0;
    end else if (s1_adv) begin
      s1_vld <= in_hs;
      if (in_hs) begin
        s1_std <= std_m;
        s1_cmp <= cmp_m;
        s1_pol <= |cmp_m;
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      s2_vld        <= 1'b0;
      st.o_is_unary <= 1'b0;
      st.o_polarity <= 1'b0;
      st.o_count    <= '0;
    end else if (s2_adv) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        st.o_is_unary <= |{s1_std, s1_cmp};
        st.o_polarity <= s1_pol;
        st.o_count    <= enc;
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst)
      o_reject_cnt <= '0;
    else if (i_clr)
      o_reject_cnt <= '0;
    else if (out_hs && !st.o_is_unary && !(&o_reject_cnt))
      o_reject_cnt <= o_reject_cnt + 1'b1;
  end
endmodule
